// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with 2-flop synchroniser, one-cycle o_valid and sticky framing error.
// Define UART_RX_PARITY_EN for 8E1 framing with an added sticky o_parity_err output.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk_25mhz,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err
`ifdef UART_RX_PARITY_EN
   ,output logic       o_parity_err
`endif
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          tick_half, tick_full, accept, frame_bad, par_ok;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par_bad;
    assign par_ok = !par_bad;
`else
    localparam state_t AFTER_DATA = STOP;
    assign par_ok = 1'b1;
`endif

    assign tick_half = cnt == HALF;
    assign tick_full = cnt == FULL;
    assign accept    = state == STOP && tick_full && rx_s && par_ok;
    assign frame_bad = state == STOP && tick_full && !rx_s;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rx_s ? IDLE : START;
            START:   state_n = !tick_half ? START : (rx_s ? IDLE : DATA);
            DATA:    state_n = (tick_full && idx == 3'd7) ? AFTER_DATA : DATA;
            PARITY:  state_n = tick_full ? STOP : PARITY;
            STOP:    state_n = !tick_full ? STOP : (rx_s ? IDLE : BREAK);
            BREAK:   state_n = rx_s ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            rx_m    <= i_rx;
            rx_s    <= rx_m;
            state   <= state_n;
            // tick_full restarts the timer so consecutive data bits stay one bit period apart
            cnt     <= (state_n != state || tick_full) ? '0 : cnt + 1'b1;
            o_valid <= accept;
            if (state == START)
                idx <= '0;
            else if (state == DATA && tick_full) begin
                idx   <= idx + 3'd1;
                shift <= {rx_s, shift[7:1]};
            end
            if (accept) begin
                o_data      <= shift;
                o_frame_err <= 1'b0;
            end
            if (frame_bad)
                o_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            if (state == PARITY && tick_full) begin
                par_bad      <= ^{shift, rx_s};
                o_parity_err <= o_parity_err | ^{shift, rx_s};
            end
            if (accept)
                o_parity_err <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed frames; expected bytes and arrival cycles queued by stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_uart_rx_byte;
    localparam int CPB = 217;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 10 * CPB;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB;
`endif

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    logic       clk_25mhz = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic       prev_valid = 1'b0;
    exp_t       exp_q[$];

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk_25mhz   (clk_25mhz),
        .rst_n       (rst_n),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err)
`ifdef UART_RX_PARITY_EN
       ,.o_parity_err(o_parity_err)
`endif
    );

    always #20 clk_25mhz = ~clk_25mhz;
    always @(posedge clk_25mhz) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_25mhz) begin
        if (o_valid) begin
            chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got data %0h expected no strobe (cycle %0d)", o_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_data", {24'd0, o_data}, {24'd0, e.d});
                chk("frame_err_on_accept", {31'd0, o_frame_err}, 32'd0);
                n_cmp++;
                if (cyc < e.c - 1 || cyc > e.c + 1) begin
                    n_err++;
                    $display("FAIL valid_cycle: got %0d expected %0d +/-1", cyc, e.c);
                end
            end
        end
        prev_valid = o_valid;
    end

    task automatic bit_(input logic b, input int n);
        i_rx = b;
        repeat (n) @(posedge clk_25mhz);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input bit expect_ok);
        if (expect_ok) exp_q.push_back('{b, cyc + LAT});
        bit_(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        bit_(^b, CPB);
`endif
        bit_(stop, CPB);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_bad_parity(input logic [7:0] b);
        bit_(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_(b[i], CPB);
        bit_(~^b, CPB);
        bit_(1'b1, CPB);
    endtask
`endif

    initial begin
        logic [7:0] b3;
        b3 = 8'h77;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_25mhz);
            #1;
            i_rx = i[0];
            @(negedge clk_25mhz);
            chk("reset_data", {24'd0, o_data}, 32'h00);
            chk("reset_valid", {31'd0, o_valid}, 32'd0);
            chk("reset_frame_err", {31'd0, o_frame_err}, 32'd0);
        end
        @(posedge clk_25mhz);
        #1;
        i_rx = 1'b1;
        rst_n = 1'b1;
        bit_(1'b1, 20);

        send(8'hA5, 1'b1, 1'b1);
        bit_(1'b1, 10);
        chk("a5_data", {24'd0, o_data}, 32'hA5);
        chk("a5_frame_err", {31'd0, o_frame_err}, 32'd0);

        bit_(1'b0, 50);
        bit_(1'b1, CPB);
        chk("false_start_data", {24'd0, o_data}, 32'hA5);
        send(8'h5A, 1'b1, 1'b1);
        bit_(1'b1, 10);
        chk("5a_data", {24'd0, o_data}, 32'h5A);

        send(8'h3C, 1'b0, 1'b0);
        bit_(1'b0, 3000);
        chk("break_frame_err", {31'd0, o_frame_err}, 32'd1);
        chk("break_data_held", {24'd0, o_data}, 32'h5A);
        bit_(1'b1, 2 * CPB);
        chk("frame_err_sticky", {31'd0, o_frame_err}, 32'd1);
        send(8'h11, 1'b1, 1'b1);
        bit_(1'b1, 10);
        chk("11_data", {24'd0, o_data}, 32'h11);
        chk("11_frame_err_clr", {31'd0, o_frame_err}, 32'd0);

        send(8'h00, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b1);
        bit_(1'b1, 10);
        chk("ff_data", {24'd0, o_data}, 32'hFF);

        bit_(1'b0, CPB);
        for (int i = 0; i < 4; i++) bit_(b3[i], CPB);
        bit_(b3[4], CPB / 2);
        rst_n = 1'b0;
        #1;
        chk("midframe_rst_data", {24'd0, o_data}, 32'h00);
        chk("midframe_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("midframe_rst_frame_err", {31'd0, o_frame_err}, 32'd0);
        i_rx = 1'b1;
        repeat (5) @(posedge clk_25mhz);
        #1;
        rst_n = 1'b1;
        bit_(1'b1, 20);
        send(8'h42, 1'b1, 1'b1);
        bit_(1'b1, 10);
        chk("42_data", {24'd0, o_data}, 32'h42);

`ifdef UART_RX_PARITY_EN
        send(8'h81, 1'b1, 1'b1);
        bit_(1'b1, 10);
        chk("81_data", {24'd0, o_data}, 32'h81);
        chk("81_parity_err", {31'd0, o_parity_err}, 32'd0);
        send_bad_parity(8'h81);
        bit_(1'b1, 10);
        chk("bad_parity_flag", {31'd0, o_parity_err}, 32'd1);
        chk("bad_parity_data_held", {24'd0, o_data}, 32'h81);
`endif

        bit_(1'b1, CPB);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
